// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the sequential chunked add/subtract unit.
package adder_seq_pkg;

  // Controller states: waiting, slicing through the operands, result ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encoding of the sub input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_seq_nbit_chunk_adder.sv
// Combinational CHUNK_WIDTH-bit ripple-carry adder; one slice of the
// sequential add is computed through this block each clock.
module chunk_adder #(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   carry_in,
  output logic [CHUNK_WIDTH-1:0] sum,
  output logic                   carry_out
);

  logic [CHUNK_WIDTH:0] w_c;

  assign w_c[0] = carry_in;

  for (genvar gi = 0; gi < CHUNK_WIDTH; gi++) begin : g_bit
    assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
  end

  assign carry_out = w_c[CHUNK_WIDTH];

endmodule

// File: rtl/adder_seq_nbit.sv
// Multi-cycle add/subtract unit: BIT_WIDTH operands are summed CHUNK_WIDTH
// bits per clock with the carry registered between slices, behind a
// start/busy/done handshake.
// Optional build macro ADDER_SEQ_SAT_EN: saturate sum on signed overflow.
module adder_seq_nbit
  import adder_seq_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);

  localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int MSB        = BIT_WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_carry;
  logic [BIT_WIDTH-1:0]   r_a;
  logic [BIT_WIDTH-1:0]   r_b;
  logic [BIT_WIDTH-1:0]   r_acc;
  logic [BIT_WIDTH-1:0]   w_acc_next;
  logic [CHUNK_WIDTH-1:0] w_a_slice;
  logic [CHUNK_WIDTH-1:0] w_b_slice;
  logic [CHUNK_WIDTH-1:0] w_slice_sum;
  logic                   w_slice_cout;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_ovf;

`ifdef ADDER_SEQ_SAT_EN
  // Clamp value for a signed overflow: most-negative when the operands
  // were negative, most-positive otherwise.
  function automatic logic [BIT_WIDTH-1:0] sat_value(input logic neg);
    sat_value = neg ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                    : {1'b0, {(BIT_WIDTH-1){1'b1}}};
  endfunction
`endif

  // A request is taken only when no computation is in flight.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == ADD) && (r_cnt == LAST_CNT);

  assign w_a_slice = r_a[int'(r_cnt)*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign w_b_slice = r_b[int'(r_cnt)*CHUNK_WIDTH +: CHUNK_WIDTH];

  chunk_adder #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_chunk_adder (
    .a        (w_a_slice),
    .b        (w_b_slice),
    .carry_in (r_carry),
    .sum      (w_slice_sum),
    .carry_out(w_slice_cout)
  );

  // Accumulator with the current slice merged in; on the last slice this
  // is the full wrapped result.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(r_cnt)*CHUNK_WIDTH +: CHUNK_WIDTH] = w_slice_sum;
  end

  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign w_ovf = (r_a[MSB] == r_b[MSB]) && (w_acc_next[MSB] != r_a[MSB]);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = ADD;
      ADD:     if (r_cnt == LAST_CNT) w_state_next = DONE;
      DONE:    w_state_next = start ? ADD : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (r_state == ADD);
    done = (r_state == DONE);
  end

  // Slice counter and inter-slice carry; subtract seeds the carry with 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_carry <= (sub == MODE_SUB) ? 1'b1 : carry_in;
    end else if (r_state == ADD) begin
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
      r_carry <= w_slice_cout;
    end
  end

  // Operand capture and slice accumulation; no reset needed since every
  // slice is overwritten before the result is used.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= (sub == MODE_SUB) ? ~b : b;
    end else if (r_state == ADD) begin
      r_acc <= w_acc_next;
    end
  end

  // Result registers update only at the completion edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (w_last) begin
`ifdef ADDER_SEQ_SAT_EN
      sum       <= w_ovf ? sat_value(r_a[MSB]) : w_acc_next;
`else
      sum       <= w_acc_next;
`endif
      carry_out <= w_slice_cout;
      overflow  <= w_ovf;
    end
  end

endmodule
